// File: rtl/rprelu_pkg.sv
// Shared definitions for the RPReLU parameter path.
// Contents:
//   RPRELU_PARA_WIDTH - default width of one beta/gamma/zeta word (shared with rprelu)
//   NUM_SECT          - number of parameter sections per set (beta, gamma, zeta)
//   state_e           - loader FSM states
//   sect_e            - stream section currently being filled
//   next_sect()       - section that follows a given one in stream order
package rprelu_pkg;

    localparam int RPRELU_PARA_WIDTH = 16;
    localparam int NUM_SECT          = 3;

    typedef enum logic [1:0] {IDLE, LOAD, PEND} state_e;

    typedef enum logic [1:0] {SEC_BETA, SEC_GAMMA, SEC_ZETA} sect_e;

    // Stream order is beta, gamma, zeta; zeta is terminal.
    function automatic sect_e next_sect(input sect_e s);
        case (s)
            SEC_BETA:  return SEC_GAMMA;
            SEC_GAMMA: return SEC_ZETA;
            default:   return SEC_ZETA;
        endcase
    endfunction

endpackage

// File: rtl/rprelu_param_bank.sv
// One parameter section (beta, gamma or zeta): a shadow array filled one word
// at a time, and an active array that takes the whole shadow array in one edge.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset, clears shadow and active arrays
//   wr_en_i   - write wr_data_i into shadow[wr_addr_i]
//   wr_addr_i - channel index of the shadow write
//   wr_data_i - word to store (bit-exact)
//   swap_i    - copy every shadow entry into the active array
//   active_o  - active array seen by the datapath
module rprelu_param_bank
    import rprelu_pkg::*;
#(
    parameter int PARA_WIDTH  = RPRELU_PARA_WIDTH,
    parameter int CHANNEL_NUM = 128,
    parameter int CNT_WIDTH   = $clog2(CHANNEL_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [CNT_WIDTH-1:0]  wr_addr_i,
    input  logic [PARA_WIDTH-1:0] wr_data_i,
    input  logic                  swap_i,
    output logic [PARA_WIDTH-1:0] active_o [CHANNEL_NUM]
);

    logic [PARA_WIDTH-1:0] shadow_q [CHANNEL_NUM];
    logic [PARA_WIDTH-1:0] active_q [CHANNEL_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_addr_i] <= wr_data_i;
            end
            // Whole-array copy so the datapath never observes a mixed set.
            if (swap_i) begin
                for (int i = 0; i < CHANNEL_NUM; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/rprelu_param_loader.sv
// Writer side of the RPReLU parameter interface. Accepts a serial stream of
// beta[0..N-1], gamma[0..N-1], zeta[0..N-1] into shadow banks, then swaps all
// three into the active arrays in a single edge once the datapath is idle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   load_start      - begin a load (IDLE only; wins over load_abort in IDLE)
//   load_abort      - drop the load in progress; active arrays untouched
//   param_in_valid  - stream word valid
//   param_in        - stream word
//   param_in_ready  - loader accepts a word this cycle (LOAD state)
//   swap_en         - datapath idle, a pending swap may commit
//   beta/gamma/zeta - active parameter arrays
//   params_valid    - sticky: a complete set has been swapped in since reset
//   busy            - FSM not in IDLE
module rprelu_param_loader
    import rprelu_pkg::*;
#(
    parameter int PARA_WIDTH  = RPRELU_PARA_WIDTH,
    parameter int CHANNEL_NUM = 128,
    parameter int CNT_WIDTH   = $clog2(CHANNEL_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic                  param_in_valid,
    input  logic [PARA_WIDTH-1:0] param_in,
    output logic                  param_in_ready,
    input  logic                  swap_en,
    output logic [PARA_WIDTH-1:0] beta  [CHANNEL_NUM],
    output logic [PARA_WIDTH-1:0] gamma [CHANNEL_NUM],
    output logic [PARA_WIDTH-1:0] zeta  [CHANNEL_NUM],
    output logic                  params_valid,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] LAST_CH = CNT_WIDTH'(CHANNEL_NUM - 1);

    state_e                 state_q, state_d;
    sect_e                  sect_q, sect_d;
    logic [CNT_WIDTH-1:0]   ch_q, ch_d;
    logic                   pvalid_q, pvalid_d;
    logic                   busy_q;
    logic                   xfer;
    logic                   swap;
    logic [NUM_SECT-1:0]    wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sect_q   <= SEC_BETA;
            ch_q     <= '0;
            pvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sect_q   <= sect_d;
            ch_q     <= ch_d;
            pvalid_q <= pvalid_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        sect_d   = sect_q;
        ch_d     = ch_q;
        pvalid_d = pvalid_q;
        xfer     = 1'b0;
        swap     = 1'b0;
        case (state_q)
            IDLE: begin
                // load_start outranks a coincident load_abort here.
                if (load_start) begin
                    state_d = LOAD;
                    sect_d  = SEC_BETA;
                    ch_d    = '0;
                end
            end
            LOAD: begin
                // Abort drops any word presented in the same cycle.
                if (load_abort) begin
                    state_d = IDLE;
                end else if (param_in_valid) begin
                    xfer = 1'b1;
                    if (ch_q == LAST_CH) begin
                        ch_d = '0;
                        if (sect_q == SEC_ZETA) begin
                            state_d = PEND;
                        end else begin
                            sect_d = next_sect(sect_q);
                        end
                    end else begin
                        ch_d = ch_q + CNT_WIDTH'(1);
                    end
                end
            end
            PEND: begin
                if (load_abort) begin
                    state_d = IDLE;
                end else if (swap_en) begin
                    swap     = 1'b1;
                    pvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en = '0;
        wr_en[sect_q] = xfer;
    end

    rprelu_param_bank #(
        .PARA_WIDTH (PARA_WIDTH),
        .CHANNEL_NUM(CHANNEL_NUM),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_bank_beta (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (wr_en[SEC_BETA]),
        .wr_addr_i(ch_q),
        .wr_data_i(param_in),
        .swap_i   (swap),
        .active_o (beta)
    );

    rprelu_param_bank #(
        .PARA_WIDTH (PARA_WIDTH),
        .CHANNEL_NUM(CHANNEL_NUM),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_bank_gamma (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (wr_en[SEC_GAMMA]),
        .wr_addr_i(ch_q),
        .wr_data_i(param_in),
        .swap_i   (swap),
        .active_o (gamma)
    );

    rprelu_param_bank #(
        .PARA_WIDTH (PARA_WIDTH),
        .CHANNEL_NUM(CHANNEL_NUM),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_bank_zeta (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (wr_en[SEC_ZETA]),
        .wr_addr_i(ch_q),
        .wr_data_i(param_in),
        .swap_i   (swap),
        .active_o (zeta)
    );

    assign param_in_ready = (state_q == LOAD);
    assign params_valid   = pvalid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_rprelu_param_loader.sv
// Bench for rprelu_param_loader: a 4-channel instance for the functional
// scenarios and a 128-channel instance for the full-size reset-in-PEND case.
// Expected active arrays come from a word list: entry s*N+k of the stream is
// section s, channel k.
module tb_rprelu_param_loader;

    localparam int W  = 16;
    localparam int NA = 4;
    localparam int NB = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---- 4-channel instance ----
    logic         a_rst = 1'b0, a_start = 1'b0, a_abort = 1'b0, a_valid = 1'b0, a_swap = 1'b0;
    logic [W-1:0] a_data = '0;
    logic         a_ready, a_pv, a_busy;
    logic [W-1:0] a_beta [NA];
    logic [W-1:0] a_gamma[NA];
    logic [W-1:0] a_zeta [NA];

    rprelu_param_loader #(.PARA_WIDTH(W), .CHANNEL_NUM(NA)) dut_a (
        .clk(clk), .rst(a_rst), .load_start(a_start), .load_abort(a_abort),
        .param_in_valid(a_valid), .param_in(a_data), .param_in_ready(a_ready),
        .swap_en(a_swap), .beta(a_beta), .gamma(a_gamma), .zeta(a_zeta),
        .params_valid(a_pv), .busy(a_busy)
    );

    // ---- 128-channel instance ----
    logic         b_rst = 1'b0, b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0, b_swap = 1'b0;
    logic [W-1:0] b_data = '0;
    logic         b_ready, b_pv, b_busy;
    logic [W-1:0] b_beta [NB];
    logic [W-1:0] b_gamma[NB];
    logic [W-1:0] b_zeta [NB];

    rprelu_param_loader #(.PARA_WIDTH(W), .CHANNEL_NUM(NB)) dut_b (
        .clk(clk), .rst(b_rst), .load_start(b_start), .load_abort(b_abort),
        .param_in_valid(b_valid), .param_in(b_data), .param_in_ready(b_ready),
        .swap_en(b_swap), .beta(b_beta), .gamma(b_gamma), .zeta(b_zeta),
        .params_valid(b_pv), .busy(b_busy)
    );

    // Reference model: words to stream, and what the active arrays should hold.
    logic [W-1:0] a_words [3*NA];
    logic [W-1:0] a_exp   [3*NA];
    logic [W-1:0] b_words [3*NB];
    logic [W-1:0] b_exp   [3*NB];

    function automatic logic [W-1:0] a_act(input int idx);
        int s = idx / NA;
        int k = idx % NA;
        if (s == 0) return a_beta[k];
        if (s == 1) return a_gamma[k];
        return a_zeta[k];
    endfunction

    function automatic logic [W-1:0] b_act(input int idx);
        int s = idx / NB;
        int k = idx % NB;
        if (s == 0) return b_beta[k];
        if (s == 1) return b_gamma[k];
        return b_zeta[k];
    endfunction

    // A completed swap makes the active set equal to the streamed words.
    task automatic a_commit();
        for (int i = 0; i < 3*NA; i++) a_exp[i] = a_words[i];
    endtask

    task automatic a_reset();
        @(negedge clk);
        a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_valid = 1'b0; a_swap = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_rst = 1'b0;
        for (int i = 0; i < 3*NA; i++) a_exp[i] = '0;
    endtask

    task automatic a_begin();
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    // Streams a_words starting at a negedge with the FSM in LOAD. gaps: 0 none,
    // 1 valid toggles every cycle, 2 random. start_at pulses load_start once when
    // that many words have gone; abort_at raises load_abort (with a live word)
    // when that many words have gone, then returns. Ends at the negedge after
    // the last transfer edge.
    task automatic a_stream(input int gaps, input int start_at, input int abort_at);
        int  i = 0;
        int  cyc = 0;
        bit  pulsed = 1'b0;
        bit  xfer;
        while (i < 3*NA && cyc < 400) begin
            if (i == abort_at) begin
                a_abort = 1'b1; a_valid = 1'b1; a_data = 16'hA5A5;
                @(negedge clk);
                a_abort = 1'b0; a_valid = 1'b0;
                return;
            end
            case (gaps)
                0:       a_valid = 1'b1;
                1:       a_valid = (cyc % 2 == 0);
                default: a_valid = 1'($urandom_range(0, 1));
            endcase
            a_data  = a_valid ? a_words[i] : W'($urandom);
            a_start = (i == start_at && !pulsed);
            if (a_start) pulsed = 1'b1;
            xfer = a_valid && a_ready;
            @(negedge clk);
            if (xfer) i++;
            cyc++;
        end
        a_valid = 1'b0;
        a_start = 1'b0;
        checks++;
        if (i != 3*NA) begin
            errors++;
            $display("FAIL a_stream_done: transferred %0d words, required %0d", i, 3*NA);
        end
    endtask

    task automatic test_reset();
        a_reset();
        repeat (10) @(negedge clk);
        checks++;
        if (a_pv !== 1'b0) begin errors++; $display("FAIL reset_pv: got %b want 0", a_pv); end
        checks++;
        if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", a_ready); end
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        for (int i = 0; i < 3*NA; i++) begin
            checks++;
            if (a_act(i) !== '0) begin errors++; $display("FAIL reset_active[%0d]: got %h want 0", i, a_act(i)); end
        end
    endtask

    task automatic test_basic_load();
        for (int i = 0; i < 3*NA; i++) a_words[i] = W'(i + 1);
        a_swap = 1'b1;
        a_begin();
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_in_load: got %b want 1", a_ready); end
        a_stream(0, -1, -1);
        // One cycle after the last transfer: in PEND, swap not yet committed.
        checks++;
        if (a_pv !== 1'b0) begin errors++; $display("FAIL basic_pv_early: got %b want 0", a_pv); end
        checks++;
        if (a_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_pend: got %b want 0", a_ready); end
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_pend: got %b want 1", a_busy); end
        @(negedge clk);
        a_commit();
        checks++;
        if (a_pv !== 1'b1) begin errors++; $display("FAIL basic_pv_rise: got %b want 1", a_pv); end
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b want 0", a_busy); end
        for (int i = 0; i < 3*NA; i++) begin
            checks++;
            if (a_act(i) !== a_exp[i]) begin errors++; $display("FAIL basic_active[%0d]: got %h want %h", i, a_act(i), a_exp[i]); end
        end
        a_swap = 1'b0;
    endtask

    task automatic test_gaps_swap_hold();
        a_reset();
        for (int i = 0; i < 3*NA; i++) a_words[i] = W'(i + 1);
        a_begin();
        a_stream(1, -1, -1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (a_ready !== 1'b0 || a_busy !== 1'b1 || a_pv !== 1'b0 || a_beta[0] !== '0 || a_zeta[NA-1] !== '0) begin
                errors++;
                $display("FAIL hold_pend cyc %0d: ready %b busy %b pv %b beta0 %h zeta3 %h, want 0 1 0 0 0",
                         c, a_ready, a_busy, a_pv, a_beta[0], a_zeta[NA-1]);
            end
            @(negedge clk);
        end
        a_swap = 1'b1;
        @(negedge clk);
        a_swap = 1'b0;
        a_commit();
        checks++;
        if (a_pv !== 1'b1) begin errors++; $display("FAIL hold_pv: got %b want 1", a_pv); end
        for (int i = 0; i < 3*NA; i++) begin
            checks++;
            if (a_act(i) !== a_exp[i]) begin errors++; $display("FAIL hold_active[%0d]: got %h want %h", i, a_act(i), a_exp[i]); end
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3*NA; i++) a_words[i] = 16'hFFFF;
        a_swap = 1'b1;
        a_begin();
        a_stream(0, -1, 6);
        checks++;
        if (a_busy !== 1'b0 || a_ready !== 1'b0) begin
            errors++; $display("FAIL abort_load_idle: busy %b ready %b want 0 0", a_busy, a_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (a_pv !== 1'b1) begin errors++; $display("FAIL abort_pv: got %b want 1", a_pv); end
        for (int i = 0; i < 3*NA; i++) begin
            checks++;
            if (a_act(i) !== a_exp[i]) begin errors++; $display("FAIL abort_active[%0d]: got %h want %h", i, a_act(i), a_exp[i]); end
        end
        // Abort in PEND coinciding with swap_en: the swap must be dropped.
        a_swap = 1'b0;
        a_begin();
        a_stream(0, -1, -1);
        a_abort = 1'b1; a_swap = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_pend_idle: busy %b want 0", a_busy); end
        repeat (3) @(negedge clk);
        a_swap = 1'b0;
        for (int i = 0; i < 3*NA; i++) begin
            checks++;
            if (a_act(i) !== a_exp[i]) begin errors++; $display("FAIL abort_pend_active[%0d]: got %h want %h", i, a_act(i), a_exp[i]); end
        end
    endtask

    task automatic test_start_ignored_and_start_wins();
        for (int i = 0; i < 3*NA; i++) a_words[i] = W'($urandom);
        a_swap = 1'b1;
        a_begin();
        a_stream(0, 3, -1);
        @(negedge clk);
        a_swap = 1'b0;
        a_commit();
        for (int i = 0; i < 3*NA; i++) begin
            checks++;
            if (a_act(i) !== a_exp[i]) begin errors++; $display("FAIL restart_active[%0d]: got %h want %h", i, a_act(i), a_exp[i]); end
        end
        // In IDLE, start together with abort enters LOAD.
        a_start = 1'b1; a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_abort = 1'b0;
        checks++;
        if (a_busy !== 1'b1 || a_ready !== 1'b1) begin
            errors++; $display("FAIL start_wins: busy %b ready %b want 1 1", a_busy, a_ready);
        end
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL start_wins_abort: busy %b want 0", a_busy); end
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 4; it++) begin
            int d;
            for (int i = 0; i < 3*NA; i++) a_words[i] = W'($urandom);
            d = $urandom_range(0, 4);
            a_swap = 1'b0;
            a_begin();
            a_stream(2, -1, -1);
            repeat (d) @(negedge clk);
            a_swap = 1'b1;
            @(negedge clk);
            a_swap = 1'b0;
            a_commit();
            for (int i = 0; i < 3*NA; i++) begin
                checks++;
                if (a_act(i) !== a_exp[i]) begin errors++; $display("FAIL random%0d_active[%0d]: got %h want %h", it, i, a_act(i), a_exp[i]); end
            end
        end
    endtask

    // Full-size stream with continuous valid; ends at the negedge after the last transfer.
    task automatic b_load();
        int i = 0;
        int cyc = 0;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        while (i < 3*NB && cyc < 2000) begin
            bit xfer;
            b_valid = 1'b1;
            b_data  = b_words[i];
            xfer = b_ready;
            @(negedge clk);
            if (xfer) i++;
            cyc++;
        end
        b_valid = 1'b0;
        checks++;
        if (i != 3*NB) begin errors++; $display("FAIL b_stream_done: transferred %0d words, required %0d", i, 3*NB); end
    endtask

    task automatic test_rst_in_pend_128();
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        for (int i = 0; i < 3*NB; i++) b_words[i] = W'($urandom);
        b_swap = 1'b1;
        b_load();
        @(negedge clk);
        b_swap = 1'b0;
        for (int i = 0; i < 3*NB; i++) b_exp[i] = b_words[i];
        for (int i = 0; i < 3*NB; i++) begin
            checks++;
            if (b_act(i) !== b_exp[i]) begin errors++; $display("FAIL big_active[%0d]: got %h want %h", i, b_act(i), b_exp[i]); end
        end
        for (int i = 0; i < 3*NB; i++) b_words[i] = W'($urandom);
        b_load();
        checks++;
        if (b_busy !== 1'b1 || b_pv !== 1'b1) begin
            errors++; $display("FAIL big_pend: busy %b pv %b want 1 1", b_busy, b_pv);
        end
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        checks++;
        if (b_pv !== 1'b0 || b_busy !== 1'b0 || b_ready !== 1'b0) begin
            errors++; $display("FAIL big_rst_ctrl: pv %b busy %b ready %b want 0 0 0", b_pv, b_busy, b_ready);
        end
        for (int i = 0; i < 3*NB; i++) begin
            checks++;
            if (b_act(i) !== '0) begin errors++; $display("FAIL big_rst_active[%0d]: got %h want 0", i, b_act(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gaps_swap_hold();
        test_abort();
        test_start_ignored_and_start_wins();
        test_random_loads();
        test_rst_in_pend_128();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rprelu_param_loader.md
Name: rprelu_param_loader

Overview:
- Writer side of the RPReLU parameter interface: accepts a serial word stream and fills the per-channel beta/gamma/zeta arrays that rprelu consumes.
- Loads into shadow registers, then swaps atomically into the active arrays, so the datapath never sees a half-updated set.
- Sits between the weight/parameter fetch logic and rprelu in each layer.

Parameters:
- PARA_WIDTH, 16, width of one beta/gamma/zeta word.
- CHANNEL_NUM, 128, channels per parameter set.
- CNT_WIDTH, $clog2(CHANNEL_NUM), width of the channel counter (derived).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- load_start  input  1  one-cycle pulse that begins a new load; honoured only in IDLE.
- load_abort  input  1  discards the in-progress load; active arrays unchanged.
- param_in_valid  input  1  stream word valid.
- param_in  input  PARA_WIDTH  stream word.
- param_in_ready  output  1  loader can accept a word this cycle.
- swap_en  input  1  datapath idle; a pending swap may commit this cycle.
- beta  output  PARA_WIDTH x [CHANNEL_NUM]  active beta array (unpacked).
- gamma  output  PARA_WIDTH x [CHANNEL_NUM]  active gamma array (unpacked).
- zeta  output  PARA_WIDTH x [CHANNEL_NUM]  active zeta array (unpacked).
- params_valid  output  1  active arrays hold a complete set.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values: all active and shadow entries 0; params_valid=0; param_in_ready=0; busy=0; FSM=IDLE; counters 0.
- Stream order: beta[0..N-1], then gamma[0..N-1], then zeta[0..N-1]; 3*N words total.
- FSM states: IDLE, LOAD, PEND.
- IDLE -> LOAD on load_start. Clear sect=0 and ch=0.
- LOAD: param_in_ready=1. A word transfers on valid & ready and is written to shadow[sect][ch] at that edge.
  - ch increments per transfer. At ch=N-1 it wraps to 0 and sect increments.
  - The transfer at sect=2, ch=N-1 moves the FSM to PEND.
  - No transfer while valid=0; counters hold.
- PEND: param_in_ready=0. On swap_en=1, copy all three shadow arrays to the active arrays in one edge, set params_valid=1, go to IDLE.
  - If swap_en is already high on the PEND entry cycle, the swap happens on the next edge. Minimum one cycle in PEND.
- Latency: active arrays update on the edge after the first cycle in PEND with swap_en=1; visible in the following cycle.
- params_valid is sticky after the first swap. Later loads and aborts do not clear it; only rst does.
- load_abort in LOAD or PEND: go to IDLE, ready drops next cycle, shadow contents are don't-care, active and params_valid unchanged.
  - Abort has priority over a simultaneous transfer or swap_en; that word and that swap are dropped.
- load_start outside IDLE is ignored. load_start together with load_abort in IDLE: start wins.
- rst mid-load or in PEND: full reset, including params_valid=0 and active arrays zeroed.
- busy = (state != IDLE), registered.
- No arithmetic; words are stored bit-exact, with sign interpretation left to rprelu.

Decomposition:
- Shared package rprelu_pkg:
  - state enum typedef {IDLE, LOAD, PEND}.
  - section enum {SEC_BETA, SEC_GAMMA, SEC_ZETA}.
  - localparam NUM_SECT=3.
  - PARA_WIDTH default constant, shared with rprelu.
- One natural sub-module: rprelu_param_bank. One instance per section, holding the shadow and active arrays, a write port (wr_en, wr_addr, wr_data) and a swap strobe. The top keeps the FSM and counters and instantiates three banks.

Test Plan (CHANNEL_NUM overridden to 4 unless noted):
- Reset then idle 10 cycles -> all outputs 0, params_valid=0, param_in_ready=0.
- load_start, stream words 0x0001..0x000C with continuous valid, swap_en held 1:
  - result beta={1,2,3,4}, gamma={5,6,7,8}, zeta={9,10,11,12}.
  - params_valid rises exactly 2 cycles after the 12th transfer.
- Same load with valid toggled 1/0 every cycle and swap_en low for 5 cycles in PEND:
  - active arrays stay 0 until swap_en rises.
  - identical final contents; ready=0 throughout PEND.
- After a complete load of 1..12, start a second load with 0xFFFF words and assert load_abort after word 6:
  - active arrays still hold 1..12.
  - params_valid stays 1; FSM is IDLE next cycle.
- load_start pulsed again during LOAD at word 3 -> ignored; the load completes normally with the correct ordering.
- CHANNEL_NUM=128, random 384-word stream, then rst asserted in PEND -> all arrays 0, params_valid=0, busy=0 one cycle after rst.
